serial_accumulator: RTL

Bit-serial accumulator that sits directly downstream of the 4x4 serial multiplier and consumes its product stream. Product bits arrive LSB-first, one per clock. Each product frame is added into a running ACC_W-bit sum using a single full-adder cell and a carry flop. The block publishes the updated sum with a one-cycle valid pulse and provides a sticky overflow flag. The multiply stage stays bit-serial end to end.

---
 rtl/serial_accumulator_if.sv | 36 +++
 rtl/serial_accumulator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/serial_accumulator_if.sv
// serial_accumulator_if
// Groups the product-bit stream, the clear strobe and the published
// accumulator result of serial_accumulator into one bundle.
//   master : upstream producer / consumer (drives stream and clr, reads result)
//   slave  : the accumulator itself
// Signals:
//   clr        synchronous clear of sum and overflow, aborts a frame
//   in_valid   in_bit is valid this cycle
//   in_start   marks bit 0 of a frame (only with in_valid)
//   in_bit     product bit, LSB first
//   in_ready   accumulator is idle and can take bit 0 of a new frame
//   acc        committed accumulator value
//   acc_valid  one-cycle pulse when acc was just updated by a frame
//   overflow   sticky carry-out flag
interface serial_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             clr;
  logic             in_valid;
  logic             in_start;
  logic             in_bit;
  logic             in_ready;
  logic [ACC_W-1:0] acc;
  logic             acc_valid;
  logic             overflow;

  modport master (
    output clr, in_valid, in_start, in_bit,
    input  in_ready, acc, acc_valid, overflow
  );

  modport slave (
    input  clr, in_valid, in_start, in_bit,
    output in_ready, acc, acc_valid, overflow
  );
endinterface

// File: rtl/serial_accumulator.sv
// serial_accumulator
// Bit-serial accumulator fed by the serial multiplier's product stream.
// Each FRAME_W-bit product (LSB first) is added in place into an ACC_W-bit
// working register through one full-adder cell and a carry flop, the carry
// is then rippled through the upper positions, and the result is committed
// to acc with a one-cycle acc_valid pulse.
// Parameters:
//   FRAME_W  bits per product frame
//   ACC_W    accumulator width, at least FRAME_W+1
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (priority over clr)
//   bus      serial_accumulator_if.slave (stream in, result out, clr)
// Build option:
//   SERIAL_ACC_SATURATE_EN  when defined, a frame that carries out of the
//                           top bit forces acc/work to all ones instead of
//                           wrapping. overflow is set either way.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | work == acc, in_ready high, waiting for in_valid & in_start
// SHIFT | adding product bits 1..FRAME_W-1, stalls while in_valid low
// PROP  | rippling carry through positions FRAME_W..ACC_W-1
// DONE  | latch overflow, commit work to acc, pulse acc_valid
module serial_accumulator #(
  parameter int FRAME_W = 8,
  parameter int ACC_W   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PROP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] work;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Single full-adder cell at position cnt; in PROP the addend is zero.
  logic cur_bit;
  logic add_bit;
  logic fa_sum;
  logic fa_cout;

  always_comb begin
    cur_bit = work[cnt];
    add_bit = (state == SHIFT) ? bus.in_bit : 1'b0;
    fa_sum  = cur_bit ^ add_bit ^ carry;
    fa_cout = (cur_bit & add_bit) | (carry & (cur_bit ^ add_bit));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      work          <= '0;
      carry         <= 1'b0;
      cnt           <= '0;
      bus.acc       <= '0;
      bus.acc_valid <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      bus.acc_valid <= 1'b0;
      if (bus.clr) begin
        state        <= IDLE;
        work         <= '0;
        carry        <= 1'b0;
        cnt          <= '0;
        bus.acc      <= '0;
        bus.overflow <= 1'b0;
        bus.in_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.in_valid && bus.in_start) begin
              // Bit 0 enters with no incoming carry: a half-adder step.
              work[0]      <= work[0] ^ bus.in_bit;
              carry        <= work[0] & bus.in_bit;
              cnt          <= CNT_W'(1);
              bus.in_ready <= 1'b0;
              state        <= (FRAME_W == 1) ? PROP : SHIFT;
            end
          end
          SHIFT: begin
            if (bus.in_valid) begin
              work[cnt] <= fa_sum;
              carry     <= fa_cout;
              cnt       <= cnt + 1'b1;
              if (cnt == LAST_BIT) begin
                state <= PROP;
              end
            end
          end
          PROP: begin
            work[cnt] <= fa_sum;
            carry     <= fa_cout;
            cnt       <= cnt + 1'b1;
            if (cnt == LAST_POS) begin
              state <= DONE;
            end
          end
          DONE: begin
            if (carry) begin
              bus.overflow <= 1'b1;
            end
`ifdef SERIAL_ACC_SATURATE_EN
            if (carry) begin
              work    <= '1;
              bus.acc <= '1;
            end else begin
              bus.acc <= work;
            end
`else
            bus.acc <= work;
`endif
            bus.acc_valid <= 1'b1;
            carry         <= 1'b0;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
